// File: rtl/pipelined_rv32_cpu_if.sv
// Run-control bundle of the pipelined RV32 core: start enable plus optional perf counters.
// Counter signals exist only when CPU_PERF_CNT_EN is defined.
interface pipelined_rv32_cpu_if;
  logic start_i;
`ifdef CPU_PERF_CNT_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

  modport master (output start_i, input stall_cnt_o, flush_cnt_o);
  modport slave  (input start_i, output stall_cnt_o, flush_cnt_o);
`else
  modport master (output start_i);
  modport slave  (input start_i);
`endif
endinterface

// File: rtl/pipelined_rv32_cpu.sv
// 5-stage in-order RV32 integer-subset core with forwarding, load-use stall and beq in ID.
// Optional load-use / flush counters are enabled by defining CPU_PERF_CNT_EN.
module pipelined_rv32_cpu #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  pipelined_rv32_cpu_if.slave    bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned IAW   = $clog2(IMEM_WORDS);
  localparam int unsigned DAW   = $clog2(DMEM_WORDS);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_t;

  logic [XLEN-1:0] imem [IMEM_WORDS];
  logic [XLEN-1:0] dmem [DMEM_WORDS];
  logic [XLEN-1:0] regs [32];

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] if_id_pc, if_id_instr;

  ctrl_t           id_ex_ctrl;
  logic [XLEN-1:0] id_ex_rd1, id_ex_rd2, id_ex_imm;
  logic [4:0]      id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [2:0]      id_ex_f3;
  logic            id_ex_f7b5, id_ex_f7b0;

  logic            ex_mem_reg_write, ex_mem_mem_write, ex_mem_mem_to_reg;
  logic [XLEN-1:0] ex_mem_alu, ex_mem_store;
  logic [4:0]      ex_mem_rd;

  logic            mem_wb_reg_write, mem_wb_mem_to_reg;
  logic [XLEN-1:0] mem_wb_alu, mem_wb_load;
  logic [4:0]      mem_wb_rd;

  // ID decode
  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  ctrl_t           id_ctrl;
  logic            is_beq;
  logic [XLEN-1:0] i_imm, s_imm, b_imm, id_imm, rd1, rd2, wb_data;
  logic            load_use_c, branch_taken_c;

  assign opcode = if_id_instr[6:0];
  assign rd     = if_id_instr[11:7];
  assign rs1    = if_id_instr[19:15];
  assign rs2    = if_id_instr[24:20];
  assign i_imm  = {{20{if_id_instr[31]}}, if_id_instr[31:20]};
  assign s_imm  = {{20{if_id_instr[31]}}, if_id_instr[31:25], if_id_instr[11:7]};
  assign b_imm  = {{19{if_id_instr[31]}}, if_id_instr[31], if_id_instr[7],
                   if_id_instr[30:25], if_id_instr[11:8], 1'b0};
  assign id_imm = (opcode == OP_SW) ? s_imm : i_imm;

  always_comb begin
    id_ctrl = '0;
    is_beq  = 1'b0;
    case (opcode)
      OP_R:   begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = 2'b10; end
      OP_I:   begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_src = 1'b1; id_ctrl.alu_op = 2'b11; end
      OP_LW:  begin
        id_ctrl.reg_write  = 1'b1;
        id_ctrl.mem_read   = 1'b1;
        id_ctrl.mem_to_reg = 1'b1;
        id_ctrl.alu_src    = 1'b1;
      end
      OP_SW:  begin id_ctrl.mem_write = 1'b1; id_ctrl.alu_src = 1'b1; end
      OP_BEQ: begin is_beq = 1'b1; id_ctrl.alu_op = 2'b01; end
      default: ;
    endcase
  end

  assign wb_data = mem_wb_mem_to_reg ? mem_wb_load : mem_wb_alu;

  // Register read with same-cycle writeback bypass
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs1 != 5'd0) rd1 = (mem_wb_reg_write && mem_wb_rd == rs1) ? wb_data : regs[rs1];
    if (rs2 != 5'd0) rd2 = (mem_wb_reg_write && mem_wb_rd == rs2) ? wb_data : regs[rs2];
  end

  assign load_use_c     = id_ex_ctrl.mem_read && (id_ex_rd != 5'd0) &&
                          ((id_ex_rd == rs1) || (id_ex_rd == rs2));
  // A stalled branch waits and re-evaluates with fresh operands next cycle
  assign branch_taken_c = is_beq && !load_use_c && (rd1 == rd2);

  // EX forwarding and ALU
  logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_res;

  always_comb begin
    fwd_a = id_ex_rd1;
    if (ex_mem_reg_write && ex_mem_rd != 5'd0 && ex_mem_rd == id_ex_rs1)
      fwd_a = ex_mem_alu;
    else if (mem_wb_reg_write && mem_wb_rd != 5'd0 && mem_wb_rd == id_ex_rs1)
      fwd_a = wb_data;
    fwd_b = id_ex_rd2;
    if (ex_mem_reg_write && ex_mem_rd != 5'd0 && ex_mem_rd == id_ex_rs2)
      fwd_b = ex_mem_alu;
    else if (mem_wb_reg_write && mem_wb_rd != 5'd0 && mem_wb_rd == id_ex_rs2)
      fwd_b = wb_data;
  end

  assign op_b = id_ex_ctrl.alu_src ? id_ex_imm : fwd_b;

  always_comb begin
    alu_res = fwd_a + op_b;
    case (id_ex_ctrl.alu_op)
      2'b01: alu_res = fwd_a - op_b;
      2'b10: begin
        case (id_ex_f3)
          3'b000: begin
            if (id_ex_f7b0)      alu_res = XLEN'(fwd_a * op_b);
            else if (id_ex_f7b5) alu_res = fwd_a - op_b;
          end
          3'b001:  alu_res = fwd_a << op_b[4:0];
          3'b100:  alu_res = fwd_a ^ op_b;
          3'b111:  alu_res = fwd_a & op_b;
          default: ;
        endcase
      end
      2'b11: if (id_ex_f3 == 3'b101) alu_res = XLEN'($signed(fwd_a) >>> op_b[4:0]);
      default: ;
    endcase
  end

  // IF stage and IF/ID register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc          <= '0;
      if_id_pc    <= '0;
      if_id_instr <= '0;
    end else if (load_use_c) begin
      pc          <= pc;
    end else if (branch_taken_c) begin
      pc          <= if_id_pc + b_imm;
      if_id_instr <= '0;
    end else if (bus.start_i) begin
      pc          <= pc + XLEN'(4);
      if_id_pc    <= pc;
      if_id_instr <= imem[pc[IAW+1:2]];
    end else begin
      if_id_instr <= '0;
    end
  end

  // ID/EX register; a load-use stall injects a bubble
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      id_ex_ctrl <= '0;
      id_ex_rd1  <= '0;
      id_ex_rd2  <= '0;
      id_ex_imm  <= '0;
      id_ex_rs1  <= '0;
      id_ex_rs2  <= '0;
      id_ex_rd   <= '0;
      id_ex_f3   <= '0;
      id_ex_f7b5 <= 1'b0;
      id_ex_f7b0 <= 1'b0;
    end else begin
      id_ex_ctrl <= load_use_c ? ctrl_t'('0) : id_ctrl;
      id_ex_rd1  <= rd1;
      id_ex_rd2  <= rd2;
      id_ex_imm  <= id_imm;
      id_ex_rs1  <= rs1;
      id_ex_rs2  <= rs2;
      id_ex_rd   <= rd;
      id_ex_f3   <= if_id_instr[14:12];
      id_ex_f7b5 <= if_id_instr[30];
      id_ex_f7b0 <= if_id_instr[25];
    end
  end

  // EX/MEM and MEM/WB registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_mem_reg_write  <= 1'b0;
      ex_mem_mem_write  <= 1'b0;
      ex_mem_mem_to_reg <= 1'b0;
      ex_mem_alu        <= '0;
      ex_mem_store      <= '0;
      ex_mem_rd         <= '0;
      mem_wb_reg_write  <= 1'b0;
      mem_wb_mem_to_reg <= 1'b0;
      mem_wb_alu        <= '0;
      mem_wb_load       <= '0;
      mem_wb_rd         <= '0;
    end else begin
      ex_mem_reg_write  <= id_ex_ctrl.reg_write;
      ex_mem_mem_write  <= id_ex_ctrl.mem_write;
      ex_mem_mem_to_reg <= id_ex_ctrl.mem_to_reg;
      ex_mem_alu        <= alu_res;
      ex_mem_store      <= fwd_b;
      ex_mem_rd         <= id_ex_rd;
      mem_wb_reg_write  <= ex_mem_reg_write;
      mem_wb_mem_to_reg <= ex_mem_mem_to_reg;
      mem_wb_alu        <= ex_mem_alu;
      mem_wb_load       <= dmem[ex_mem_alu[DAW+1:2]];
      mem_wb_rd         <= ex_mem_rd;
    end
  end

  // Storage arrays are not reset; they are preloaded externally
  always_ff @(posedge clk_i) begin
    if (ex_mem_mem_write) dmem[ex_mem_alu[DAW+1:2]] <= ex_mem_store;
    if (mem_wb_reg_write && mem_wb_rd != 5'd0) regs[mem_wb_rd] <= wb_data;
  end

`ifdef CPU_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (load_use_c && stall_cnt_q != '1)     stall_cnt_q <= stall_cnt_q + 32'd1;
      if (branch_taken_c && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipelined_rv32_cpu.sv
// Directed bench for pipelined_rv32_cpu: programs are loaded hierarchically, results checked
// against hand-computed values. Counter checks are compiled in with CPU_PERF_CNT_EN.
module tb_pipelined_rv32_cpu;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   holds  = 0;

  pipelined_rv32_cpu_if bus ();

  pipelined_rv32_cpu dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction

  task automatic hold_reset();
    rst_i       = 1'b0;
    bus.start_i = 1'b0;
    #1;
    for (int i = 0; i < 256; i++) dut.imem[i] = 32'd0;
    for (int i = 0; i < 32; i++) begin
      dut.dmem[i] = 32'd0;
      dut.regs[i] = 32'd0;
    end
  endtask

  task automatic release_reset();
    @(negedge clk_i);
    rst_i       = 1'b1;
    bus.start_i = 1'b1;
    holds       = 0;
  endtask

  // Advance n cycles, counting cycles in which the PC did not move
  task automatic run_cycles(input int n);
    logic [31:0] prev;
    for (int i = 0; i < n; i++) begin
      prev = dut.pc;
      @(negedge clk_i);
      if (dut.pc === prev) holds++;
    end
  endtask

  task automatic test_reset();
    hold_reset();
    @(negedge clk_i);
    checks++; if (dut.pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h want 0", dut.pc); end
    checks++; if (dut.if_id_instr !== 32'd0) begin errors++; $display("FAIL reset_ifid got %h want 0", dut.if_id_instr); end
    checks++; if (dut.ex_mem_reg_write !== 1'b0 || dut.mem_wb_reg_write !== 1'b0) begin
      errors++; $display("FAIL reset_bubble got %b%b want 00", dut.ex_mem_reg_write, dut.mem_wb_reg_write);
    end
`ifdef CPU_PERF_CNT_EN
    checks++; if (bus.stall_cnt_o !== 32'd0 || bus.flush_cnt_o !== 32'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", bus.stall_cnt_o, bus.flush_cnt_o);
    end
`endif
  endtask

  task automatic test_nop_fetch();
    hold_reset();
    dut.regs[3] = 32'h1234;
    dut.dmem[0] = 32'hA5;
    release_reset();
    run_cycles(1);
    checks++; if (dut.pc !== 32'd4) begin errors++; $display("FAIL nop_pc1 got %h want 4", dut.pc); end
    run_cycles(4);
    checks++; if (dut.pc !== 32'd20) begin errors++; $display("FAIL nop_pc5 got %h want 14", dut.pc); end
    bus.start_i = 1'b0;
    run_cycles(3);
    checks++; if (dut.pc !== 32'd20) begin errors++; $display("FAIL nop_hold got %h want 14", dut.pc); end
    bus.start_i = 1'b1;
    run_cycles(4);
    checks++; if (dut.regs[3] !== 32'h1234 || dut.dmem[0] !== 32'hA5) begin
      errors++; $display("FAIL nop_state got %h/%h want 1234/a5", dut.regs[3], dut.dmem[0]);
    end
`ifdef CPU_PERF_CNT_EN
    checks++; if (bus.stall_cnt_o !== 32'd0 || bus.flush_cnt_o !== 32'd0) begin
      errors++; $display("FAIL nop_cnt got %0d/%0d want 0/0", bus.stall_cnt_o, bus.flush_cnt_o);
    end
`endif
  endtask

  task automatic test_alu_chain();
    hold_reset();
    dut.imem[0] = addi(5'd1, 5'd0, 12'd10);
    dut.imem[1] = addi(5'd2, 5'd0, 12'd3);
    dut.imem[2] = enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3);
    dut.imem[3] = enc_r(7'b0000001, 5'd2, 5'd3, 3'b000, 5'd4);
    release_reset();
    run_cycles(4);
    checks++; if (dut.regs[1] !== 32'd0) begin errors++; $display("FAIL lat_early got %h want 0", dut.regs[1]); end
    run_cycles(1);
    checks++; if (dut.regs[1] !== 32'd10) begin errors++; $display("FAIL lat_wb got %h want a", dut.regs[1]); end
    run_cycles(6);
    checks++; if (dut.regs[3] !== 32'd7) begin errors++; $display("FAIL sub_x3 got %h want 7", dut.regs[3]); end
    checks++; if (dut.regs[4] !== 32'd21) begin errors++; $display("FAIL mul_x4 got %h want 15", dut.regs[4]); end
    checks++; if (holds !== 0) begin errors++; $display("FAIL chain_stall got %0d want 0", holds); end
  endtask

  task automatic test_back_to_back();
    hold_reset();
    dut.imem[0] = addi(5'd1, 5'd0, 12'd12);
    dut.imem[1] = addi(5'd2, 5'd0, 12'd10);
    dut.imem[2] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd3);
    dut.imem[3] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd4);
    dut.imem[4] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b001, 5'd5);
    dut.imem[5] = enc_r(7'b0100000, 5'd1, 5'd2, 3'b000, 5'd6);
    dut.imem[6] = addi(5'd0, 5'd0, 12'd5);
    dut.imem[7] = enc_r(7'b0000000, 5'd0, 5'd0, 3'b000, 5'd7);
    release_reset();
    run_cycles(14);
    checks++; if (dut.regs[3] !== 32'd8) begin errors++; $display("FAIL and_x3 got %h want 8", dut.regs[3]); end
    checks++; if (dut.regs[4] !== 32'd6) begin errors++; $display("FAIL xor_x4 got %h want 6", dut.regs[4]); end
    checks++; if (dut.regs[5] !== 32'd12288) begin errors++; $display("FAIL sll_x5 got %h want 3000", dut.regs[5]); end
    checks++; if (dut.regs[6] !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_neg got %h want fffffffe", dut.regs[6]); end
    checks++; if (dut.regs[7] !== 32'd0 || dut.regs[0] !== 32'd0) begin
      errors++; $display("FAIL x0_write got %h/%h want 0/0", dut.regs[7], dut.regs[0]);
    end
  endtask

  task automatic test_load_use();
    hold_reset();
    dut.dmem[0] = 32'd5;
    dut.imem[0] = enc_i(12'd0, 5'd0, 3'b010, 5'd5, 7'b0000011);
    dut.imem[1] = enc_r(7'b0000000, 5'd5, 5'd5, 3'b000, 5'd6);
    release_reset();
    run_cycles(3);
    checks++; if (dut.pc !== 32'd8) begin errors++; $display("FAIL lu_hold got %h want 8", dut.pc); end
    run_cycles(1);
    checks++; if (dut.pc !== 32'd12) begin errors++; $display("FAIL lu_resume got %h want c", dut.pc); end
    run_cycles(6);
    checks++; if (dut.regs[6] !== 32'd10) begin errors++; $display("FAIL lu_x6 got %h want a", dut.regs[6]); end
    checks++; if (holds !== 1) begin errors++; $display("FAIL lu_stalls got %0d want 1", holds); end
`ifdef CPU_PERF_CNT_EN
    checks++; if (bus.stall_cnt_o !== 32'd1) begin errors++; $display("FAIL lu_cnt got %0d want 1", bus.stall_cnt_o); end
`endif
  endtask

  task automatic test_branch();
    hold_reset();
    dut.imem[0] = addi(5'd1, 5'd0, 12'd1);
    dut.imem[3] = enc_b(13'd8, 5'd1, 5'd1);
    dut.imem[4] = addi(5'd7, 5'd0, 12'd9);
    dut.imem[5] = addi(5'd8, 5'd0, 12'd2);
    release_reset();
    run_cycles(12);
    checks++; if (dut.regs[7] !== 32'd0) begin errors++; $display("FAIL br_flush_x7 got %h want 0", dut.regs[7]); end
    checks++; if (dut.regs[8] !== 32'd2) begin errors++; $display("FAIL br_target_x8 got %h want 2", dut.regs[8]); end
`ifdef CPU_PERF_CNT_EN
    checks++; if (bus.flush_cnt_o !== 32'd1) begin errors++; $display("FAIL br_cnt got %0d want 1", bus.flush_cnt_o); end
`endif
    hold_reset();
    dut.imem[0] = addi(5'd1, 5'd0, 12'd1);
    dut.imem[1] = addi(5'd2, 5'd0, 12'd2);
    dut.imem[4] = enc_b(13'd8, 5'd2, 5'd1);
    dut.imem[5] = addi(5'd7, 5'd0, 12'd9);
    release_reset();
    run_cycles(12);
    checks++; if (dut.regs[7] !== 32'd9) begin errors++; $display("FAIL br_nt_x7 got %h want 9", dut.regs[7]); end
  endtask

  task automatic test_store();
    hold_reset();
    dut.imem[0] = addi(5'd8, 5'd0, 12'hFF0);
    dut.imem[1] = enc_i(12'h402, 5'd8, 3'b101, 5'd9, 7'b0010011);
    dut.imem[2] = enc_s(12'd4, 5'd9, 5'd0);
    release_reset();
    run_cycles(10);
    checks++; if (dut.regs[9] !== 32'hFFFFFFFC) begin errors++; $display("FAIL srai_x9 got %h want fffffffc", dut.regs[9]); end
    checks++; if (dut.dmem[1] !== 32'hFFFFFFFC) begin errors++; $display("FAIL sw_dmem1 got %h want fffffffc", dut.dmem[1]); end
    checks++; if (dut.dmem[0] !== 32'd0) begin errors++; $display("FAIL sw_dmem0 got %h want 0", dut.dmem[0]); end
  endtask

  task automatic test_mid_reset();
    hold_reset();
    dut.imem[0] = addi(5'd10, 5'd0, 12'd7);
    dut.imem[1] = addi(5'd11, 5'd0, 12'd8);
    dut.imem[2] = addi(5'd12, 5'd0, 12'd9);
    release_reset();
    run_cycles(5);
    #2 rst_i = 1'b0;
    #1;
    checks++; if (dut.pc !== 32'd0) begin errors++; $display("FAIL mid_pc got %h want 0", dut.pc); end
    checks++; if (dut.mem_wb_reg_write !== 1'b0) begin errors++; $display("FAIL mid_drop got %b want 0", dut.mem_wb_reg_write); end
    @(negedge clk_i);
    @(negedge clk_i);
    checks++; if (dut.regs[10] !== 32'd7) begin errors++; $display("FAIL mid_keep got %h want 7", dut.regs[10]); end
    checks++; if (dut.regs[11] !== 32'd0 || dut.regs[12] !== 32'd0) begin
      errors++; $display("FAIL mid_inflight got %h/%h want 0/0", dut.regs[11], dut.regs[12]);
    end
  endtask

  initial begin
    bus.start_i = 1'b0;
    test_reset();
    test_nop_fetch();
    test_alu_chain();
    test_back_to_back();
    test_load_use();
    test_branch();
    test_store();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
